// File: rtl/nco_pkg.sv
// Shared definitions for the NCO/DDS source: quadrant encodings, dither LFSR
// constants and the quarter-wave ROM initialisation function.
package nco_pkg;

  localparam logic [1:0] QUAD_0 = 2'd0;
  localparam logic [1:0] QUAD_1 = 2'd1;
  localparam logic [1:0] QUAD_2 = 2'd2;
  localparam logic [1:0] QUAD_3 = 2'd3;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, taps on bits 15, 13, 12 and 10
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam real PI = 3.14159265358979323846;

  // Quarter-wave entry sampled at the half-step offset so that no entry is
  // zero and none exceeds the largest positive code, keeping negation safe.
  function automatic int lutValue(input int index, input int addrWidth, input int dataWidth);
    real amplitude;
    real angle;
    amplitude = real'((1 << (dataWidth - 1)) - 1);
    angle = (PI / 2.0) * (real'(index) + 0.5) / real'(1 << addrWidth);
    return $rtoi(amplitude * $sin(angle) + 0.5);
  endfunction

endpackage

// File: rtl/nco_quarter_rom.sv
// Quarter-wave sine ROM with two synchronous read ports (sin and cos address).
// The read enable lets the caller freeze the output registers on a stall.
module nco_quarter_rom
  import nco_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rdEn,
  input  logic [ADDR_WIDTH-1:0] i_sinAddr,
  input  logic [ADDR_WIDTH-1:0] i_cosAddr,
  output logic [DATA_WIDTH-1:0] o_sinData,
  output logic [DATA_WIDTH-1:0] o_cosData
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] w_table [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_table
    assign w_table[gi] = DATA_WIDTH'(lutValue(gi, ADDR_WIDTH, DATA_WIDTH));
  end

  // Registered dual-port read; holds its outputs while the read enable is low
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_sinData <= '0;
      o_cosData <= '0;
    end else if (i_rdEn) begin
      o_sinData <= w_table[i_sinAddr];
      o_cosData <= w_table[i_cosAddr];
    end
  end

endmodule

// File: rtl/nco_dds_source.sv
// Numerically controlled oscillator producing packed {sin, cos} samples on an
// AXI-Stream style output with backpressure. Three-stage pipeline: phase
// capture, ROM read, sign/mirror into the output register.
// Optional phase dither is enabled by defining NCO_DITHER_EN.
module nco_dds_source
  import nco_pkg::*;
#(
  parameter int PHASE_WIDTH    = 32,
  parameter int LUT_ADDR_WIDTH = 10,
  parameter int O_WIDTH        = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [PHASE_WIDTH-1:0] fcw,
  input  logic                   fcw_load,
  input  logic                   phase_clr,
  output logic [2*O_WIDTH-1:0]   NCO_tdata,
  output logic                   NCO_tvalid,
  input  logic                   NCO_tready
);

  localparam int P_WIDTH    = LUT_ADDR_WIDTH + 2;
  localparam int TRUNC_BITS = PHASE_WIDTH - P_WIDTH;

  logic [PHASE_WIDTH-1:0]    r_fcw;
  logic [PHASE_WIDTH-1:0]    r_acc;
  logic [P_WIDTH-1:0]        r_s1Phase;
  logic                      r_s1Valid;
  logic                      r_s2Valid;
  logic                      r_s2SinNeg;
  logic                      r_s2CosNeg;
  logic                      r_s3Valid;
  logic [O_WIDTH-1:0]        r_s3Sin;
  logic [O_WIDTH-1:0]        r_s3Cos;

  logic                      w_stall;
  logic                      w_capture;
  logic [P_WIDTH-1:0]        w_phaseTop;
  logic [1:0]                w_sinQuad;
  logic [1:0]                w_cosQuad;
  logic [LUT_ADDR_WIDTH-1:0] w_a;
  logic [LUT_ADDR_WIDTH-1:0] w_sinAddr;
  logic [LUT_ADDR_WIDTH-1:0] w_cosAddr;
  logic [O_WIDTH-1:0]        w_romSin;
  logic [O_WIDTH-1:0]        w_romCos;

  assign w_stall   = r_s3Valid & ~NCO_tready;
  assign w_capture = enable & ~w_stall;

  // Frequency word register, takes effect on the following accumulator step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fcw <= '0;
    end else if (fcw_load) begin
      r_fcw <= fcw;
    end
  end

  // Phase accumulator; a clear wins over the increment in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (phase_clr) begin
      r_acc <= '0;
    end else if (w_capture) begin
      r_acc <= r_acc + r_fcw;
    end
  end

`ifdef NCO_DITHER_EN
  logic [15:0] r_lfsr;

  // Dither LFSR steps once per captured sample and freezes with the pipeline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= LFSR_SEED;
    end else if (w_capture) begin
      r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
    end
  end

  if (TRUNC_BITS > 0) begin : g_dither
    localparam int DITHER_BITS = (TRUNC_BITS < 16) ? TRUNC_BITS : 16;
    logic [PHASE_WIDTH-1:0] w_ditherWord;
    logic [PHASE_WIDTH-1:0] w_dithered;
    assign w_ditherWord = PHASE_WIDTH'(r_lfsr[DITHER_BITS-1:0]) << (TRUNC_BITS - DITHER_BITS);
    assign w_dithered   = r_acc + w_ditherWord;
    assign w_phaseTop   = w_dithered[PHASE_WIDTH-1 -: P_WIDTH];
  end else begin : g_noDither
    assign w_phaseTop = r_acc[PHASE_WIDTH-1 -: P_WIDTH];
  end
`else
  assign w_phaseTop = r_acc[PHASE_WIDTH-1 -: P_WIDTH];
`endif

  // S1: capture the truncated phase of each requested sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1Valid <= 1'b0;
      r_s1Phase <= '0;
    end else if (!w_stall) begin
      r_s1Valid <= enable;
      if (enable) begin
        r_s1Phase <= w_phaseTop;
      end
    end
  end

  assign w_sinQuad = r_s1Phase[P_WIDTH-1 -: 2];
  assign w_cosQuad = w_sinQuad + QUAD_1;
  assign w_a       = r_s1Phase[LUT_ADDR_WIDTH-1:0];
  assign w_sinAddr = ((w_sinQuad == QUAD_1) || (w_sinQuad == QUAD_3)) ? ~w_a : w_a;
  assign w_cosAddr = ((w_cosQuad == QUAD_1) || (w_cosQuad == QUAD_3)) ? ~w_a : w_a;

  nco_quarter_rom #(
    .ADDR_WIDTH(LUT_ADDR_WIDTH),
    .DATA_WIDTH(O_WIDTH)
  ) u_rom (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_rdEn   (~w_stall),
    .i_sinAddr(w_sinAddr),
    .i_cosAddr(w_cosAddr),
    .o_sinData(w_romSin),
    .o_cosData(w_romCos)
  );

  // S2: carry the valid bit and the negate flags alongside the ROM read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2Valid  <= 1'b0;
      r_s2SinNeg <= 1'b0;
      r_s2CosNeg <= 1'b0;
    end else if (!w_stall) begin
      r_s2Valid  <= r_s1Valid;
      r_s2SinNeg <= (w_sinQuad == QUAD_2) || (w_sinQuad == QUAD_3);
      r_s2CosNeg <= (w_cosQuad == QUAD_2) || (w_cosQuad == QUAD_3);
    end
  end

  // S3: apply the quadrant sign and hold the output word until accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s3Valid <= 1'b0;
      r_s3Sin   <= '0;
      r_s3Cos   <= '0;
    end else if (!w_stall) begin
      r_s3Valid <= r_s2Valid;
      r_s3Sin   <= r_s2SinNeg ? -w_romSin : w_romSin;
      r_s3Cos   <= r_s2CosNeg ? -w_romCos : w_romCos;
    end
  end

  assign NCO_tdata  = {r_s3Sin, r_s3Cos};
  assign NCO_tvalid = r_s3Valid;

endmodule

// File: tb/tb_nco_dds_source.sv
// Self-checking bench for nco_dds_source (default build, dither disabled).
// A cycle model predicts valid timing and pushes expected samples into a
// scoreboard queue; a second queue holds hand-derived golden words.
module tb_nco_dds_source;

  localparam real PI = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] fcw;
  logic        fcw_load;
  logic        phase_clr;
  logic [31:0] NCO_tdata;
  logic        NCO_tvalid;
  logic        NCO_tready;

  int assertCount = 0;
  int failCount   = 0;

  logic [31:0] scoreQ[$];
  logic [31:0] goldenQ[$];
  logic [31:0] quarterSeq [4];

  logic        mValid1;
  logic        mValid2;
  logic        mValid3;
  logic [31:0] mAcc;
  logic [31:0] mFcw;

  always #5 clk = ~clk;

  nco_dds_source #(
    .PHASE_WIDTH   (32),
    .LUT_ADDR_WIDTH(10),
    .O_WIDTH       (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .fcw       (fcw),
    .fcw_load  (fcw_load),
    .phase_clr (phase_clr),
    .NCO_tdata (NCO_tdata),
    .NCO_tvalid(NCO_tvalid),
    .NCO_tready(NCO_tready)
  );

  function automatic int roundAway(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  // Ideal sin/cos at the centre of the truncated 12-bit phase cell
  function automatic logic [31:0] expSample(input logic [31:0] phase);
    int  p;
    int  s;
    int  c;
    real th;
    p  = int'(phase[31:20]);
    th = 2.0 * PI * (real'(p) + 0.5) / 4096.0;
    s  = roundAway(32767.0 * $sin(th));
    c  = roundAway(32767.0 * $cos(th));
    return {s[15:0], c[15:0]};
  endfunction

  task automatic checkEq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input logic ready);
    checkEq("tvalid", {31'b0, NCO_tvalid}, {31'b0, mValid3});
    if (mValid3) begin
      if (scoreQ.size() == 0) begin
        checkEq("scoreboard_empty", NCO_tdata, 32'hxxxx_xxxx);
      end else begin
        checkEq("tdata", NCO_tdata, scoreQ[0]);
        if (goldenQ.size() != 0) checkEq("golden", NCO_tdata, goldenQ[0]);
        if (ready) begin
          void'(scoreQ.pop_front());
          if (goldenQ.size() != 0) void'(goldenQ.pop_front());
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic en, input logic ready, input logic load,
                               input logic clr, input logic [31:0] fcwVal);
    logic stall;
    enable     = en;
    NCO_tready = ready;
    fcw_load   = load;
    phase_clr  = clr;
    fcw        = fcwVal;
    #1;
    checkOutput(ready);
    stall = mValid3 & ~ready;
    if (!stall) begin
      if (en) scoreQ.push_back(expSample(mAcc));
      mValid3 = mValid2;
      mValid2 = mValid1;
      mValid1 = en;
    end
    if (clr) mAcc = 32'd0;
    else if (en && !stall) mAcc = mAcc + mFcw;
    if (load) mFcw = fcwVal;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic resetModel();
    mValid1 = 1'b0;
    mValid2 = 1'b0;
    mValid3 = 1'b0;
    mAcc    = 32'd0;
    mFcw    = 32'd0;
    scoreQ.delete();
    goldenQ.delete();
  endtask

  task automatic pushQuarterRounds(input int rounds);
    for (int r = 0; r < rounds; r++)
      for (int k = 0; k < 4; k++) goldenQ.push_back(quarterSeq[k]);
  endtask

  task automatic pushConstant(input int count);
    for (int k = 0; k < count; k++) goldenQ.push_back(32'h0019_7FFF);
  endtask

  task automatic drain();
    repeat (4) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    quarterSeq[0] = 32'h0019_7FFF;
    quarterSeq[1] = 32'h7FFF_FFE7;
    quarterSeq[2] = 32'hFFE7_8001;
    quarterSeq[3] = 32'h8001_0019;

    rst = 1'b1; enable = 1'b0; fcw = '0; fcw_load = 1'b0; phase_clr = 1'b0; NCO_tready = 1'b0;
    resetModel();
    repeat (2) @(negedge clk);
    checkEq("reset_tvalid", {31'b0, NCO_tvalid}, 32'd0);
    checkEq("reset_tdata", NCO_tdata, 32'd0);
    rst = 1'b0;
    $display("[TB] reset released");

    // Quarter-cycle steps
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h4000_0000);
    pushQuarterRounds(3);
    repeat (12) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    drain();

    // Backpressure after the second valid sample
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h4000_0000);
    pushQuarterRounds(3);
    repeat (4) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    repeat (8) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    drain();

    // Three-quarter steps, accumulator wraps
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'hC000_0000);
    goldenQ.push_back(quarterSeq[0]); goldenQ.push_back(quarterSeq[3]);
    goldenQ.push_back(quarterSeq[2]); goldenQ.push_back(quarterSeq[1]);
    goldenQ.push_back(quarterSeq[0]); goldenQ.push_back(quarterSeq[3]);
    goldenQ.push_back(quarterSeq[2]); goldenQ.push_back(quarterSeq[1]);
    repeat (8) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    drain();

    // Mid-stream clear together with a new frequency word
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h4000_0000);
    repeat (5) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h2000_0000);
    repeat (8) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    drain();

    // Zero frequency word gives a constant sample
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'd0);
    pushConstant(6);
    repeat (6) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    drain();

    // Asynchronous reset while a sample is valid
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h4000_0000);
    repeat (4) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    #2 rst = 1'b1;
    #1;
    checkEq("async_rst_tvalid", {31'b0, NCO_tvalid}, 32'd0);
    checkEq("async_rst_tdata", NCO_tdata, 32'd0);
    resetModel();
    @(negedge clk);
    rst = 1'b0;
    pushConstant(5);
    repeat (5) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/nco_dds_source.md
# nco_dds_source

Numerically controlled oscillator that produces the packed cos/sin sample stream consumed on the NCO data interface. It is the transmit side of that interface. A phase accumulator drives a quarter-wave sine ROM, and each output word carries `{sin, cos}`. The block sits where the vendor DDS core would otherwise be, feeding the mixers in the PSK modulator/demodulator chain, and honours AXI-Stream backpressure.

## Interface
Parameters:
- `PHASE_WIDTH`, 32: accumulator and frequency-word width.
- `LUT_ADDR_WIDTH`, 10: quarter-wave ROM address bits (N = 2^LUT_ADDR_WIDTH entries).
- `O_WIDTH`, 16: signed width of each of cos and sin.

Ports:
- `clk`, in, 1: sole clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `enable`, in, 1: request a new sample each cycle while high.
- `fcw`, in, PHASE_WIDTH: frequency control word.
- `fcw_load`, in, 1: capture `fcw` into the internal register.
- `phase_clr`, in, 1: clear the accumulator to 0.
- `NCO_tdata`, out, 2*O_WIDTH: `[O_WIDTH-1:0]` is cos, `[2*O_WIDTH-1:O_WIDTH]` is sin, both two's complement.
- `NCO_tvalid`, out, 1: AXI-Stream valid.
- `NCO_tready`, in, 1: AXI-Stream ready.

## Operation
- `fcw_reg` is loaded on `fcw_load`. The new value is used from the next accumulator step.
- Pipeline: S1 (phase capture), S2 (ROM read), S3 (sign/mirror into output register). Each stage has its own valid bit.
- `stall = NCO_tvalid & ~NCO_tready`. While stalled, all stages, the accumulator and the dither LFSR hold.
- On a cycle with `enable & ~stall`:
  - S1 captures `acc`.
  - `acc <= acc + fcw_reg`, mod 2^PHASE_WIDTH, wrap-around silent.
- When `enable` is low, no sample enters and the pipeline drains normally.
- Phase truncation: `p` = top (LUT_ADDR_WIDTH+2) bits of the phase.
  - `q = p[MSB:MSB-1]`, `a` = remaining bits.
  - sin quadrant is q. cos quadrant is q+1 mod 4, with the same `a`.
- Quadrant mapping, with `L = lut[a]` and `M = lut[N-1-a]`:
  - quadrant 0 → +L
  - quadrant 1 → +M
  - quadrant 2 → −L
  - quadrant 3 → −M
- ROM contents: `lut[i] = round((2^(O_WIDTH-1)-1)·sin(π/2·(i+0.5)/N))`.
  - The half-sample offset keeps every entry nonzero and ≤ max positive, so negation never overflows.
- `phase_clr`:
  - sets `acc <= 0` and overrides the increment that cycle.
  - does not flush samples already in the pipeline.
  - together with `fcw_load` in the same cycle, both apply.
- Reset values: `acc`, `fcw_reg` and all stage data are 0. All valid bits are 0, so `NCO_tvalid` = 0 and `NCO_tdata` = 0.

## Timing
- Latency is 3 cycles: a sample captured at edge k appears with `NCO_tvalid` = 1 after edge k+2, with no stall in between.
- Sustained throughput is 1 sample/cycle while `enable` and `NCO_tready` are high.
- Once asserted, `NCO_tvalid` and `NCO_tdata` stay stable until the cycle in which `NCO_tready` is high.
- `NCO_tvalid` never depends combinationally on `NCO_tready`.
- `NCO_tready` may be high without `NCO_tvalid`; it is ignored.
- Reset asserted mid-stream clears all state immediately. Output resumes 3 cycles after the first enabled post-reset edge.

## Configuration
- `NCO_DITHER_EN` defined:
  - a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, reset seed 16'hACE1) advances on every S1 capture.
  - its low bits are added into the phase bits just below the truncation point before truncation.
  - applies only when PHASE_WIDTH > LUT_ADDR_WIDTH+2.
- Undefined: no LFSR and pure truncation. Output is bit-exact to the ROM formula.

## Structure
- Shared package `nco_pkg`: quadrant encoding constants, the LFSR seed and taps, and the ROM-initialisation function computing `lut[i]`.
- One sub-module, `nco_quarter_rom`: synchronous-read quarter-wave ROM with two read ports (sin address and cos address) and a read enable tied to `~stall`.

## Test plan
- Reset, then `fcw_load` with `fcw` = 2^30, `enable` = 1, `NCO_tready` = 1 (defaults, dither off):
  - first valid sample at cycle 3.
  - (sin, cos) repeats (25, 32767), (32767, −25), (−25, −32767), (−32767, 25).
- Same stimulus with `NCO_tready` low for 5 cycles after the second valid sample:
  - the sample (32767, −25) is held unchanged.
  - the sequence resumes with no loss or duplication.
- `fcw` = 2^31 + 2^30, run 8 samples: the accumulator wraps with the phase sequence 0, 3/4, 1/2, 1/4 of a cycle, and outputs match.
- `fcw_load` of 2^29 plus `phase_clr` asserted in the same cycle mid-stream: the next captured phase is 0 and subsequent phase steps are 1/8 cycle. Already-captured in-flight samples still emerge.
- `rst` asserted while `NCO_tvalid` = 1: `NCO_tvalid` and `NCO_tdata` drop to 0 without a clock edge.
- `fcw` = 0 with `enable` = 1: the constant sample (25, 32767) every cycle. With `NCO_DITHER_EN`, the values stay within ±1 LSB-index of the undithered output.
